// File: rtl/picorv_mem_arbiter_if.sv
// PicoRV32-native memory bus: one requester/responder link.
// The master drives the request; the slave returns ready and read data.
interface picorv_mem_arbiter_if;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   logic              valid;
   logic              instr;
   logic [DATA_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              ready;
   logic [DATA_W-1:0] rdata;

   modport master (output valid, instr, addr, wdata, wstrb, input ready, rdata);
   modport slave  (input valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/picorv_mem_arbiter.sv
// Two-requester arbiter in front of a single PicoRV32-native memory port.
// Round-robin or fixed priority, one transfer in flight, with a BUSY watchdog.
module picorv_mem_arbiter #(
   parameter bit          RR      = 1'b1,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  resetn,
   picorv_mem_arbiter_if.slave   m0,
   picorv_mem_arbiter_if.slave   m1,
   picorv_mem_arbiter_if.master  s,
   output logic                  timeout_err
);
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   localparam logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   gnt_q, gnt_d;
   logic                   last_q, last_d;
   logic                   pick;
   logic                   s_valid_q, s_valid_d;
   logic                   s_instr_q, s_instr_d;
   logic [DATA_W-1:0]      s_addr_q, s_addr_d;
   logic [DATA_W-1:0]      s_wdata_q, s_wdata_d;
   logic [STRB_W-1:0]      s_wstrb_q, s_wstrb_d;
   logic [1:0]             ready_q, ready_d;
   logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
   logic                   err_d;
   logic                   timeout_hit;

   // A limit of zero disables the watchdog entirely.
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

   // Next-state, arbitration and completion.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      pick      = 1'b0;
      s_valid_d = s_valid_q;
      s_instr_d = s_instr_q;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      s_wstrb_d = s_wstrb_q;
      ready_d   = '0;
      rdata_d   = rdata_q;
      err_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (m0.valid || m1.valid) begin
               if (m0.valid && m1.valid) pick = RR ? ~last_q : 1'b0;
               else                      pick = m1.valid;
               gnt_d     = pick;
               last_d    = pick;
               cnt_d     = '0;
               s_valid_d = 1'b1;
               s_instr_d = pick ? m1.instr : m0.instr;
               s_addr_d  = pick ? m1.addr  : m0.addr;
               s_wdata_d = pick ? m1.wdata : m0.wdata;
               s_wstrb_d = pick ? m1.wstrb : m0.wstrb;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            // A real completion beats the watchdog in the same cycle.
            if (s.ready) begin
               s_valid_d        = 1'b0;
               ready_d[gnt_q]   = 1'b1;
               rdata_d[gnt_q]   = s.rdata;
               state_d          = RELEASE;
            end else if (timeout_hit) begin
               s_valid_d        = 1'b0;
               ready_d[gnt_q]   = 1'b1;
               rdata_d[gnt_q]   = ERR_DATA;
               err_d            = 1'b1;
               state_d          = RELEASE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; last grant resets to m1 so m0 wins first.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         gnt_q       <= 1'b0;
         last_q      <= 1'b1;
         s_valid_q   <= 1'b0;
         s_instr_q   <= 1'b0;
         s_addr_q    <= '0;
         s_wdata_q   <= '0;
         s_wstrb_q   <= '0;
         ready_q     <= '0;
         rdata_q     <= '0;
         timeout_err <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         last_q      <= last_d;
         s_valid_q   <= s_valid_d;
         s_instr_q   <= s_instr_d;
         s_addr_q    <= s_addr_d;
         s_wdata_q   <= s_wdata_d;
         s_wstrb_q   <= s_wstrb_d;
         ready_q     <= ready_d;
         rdata_q     <= rdata_d;
         timeout_err <= err_d;
      end
   end

   assign s.valid  = s_valid_q;
   assign s.instr  = s_instr_q;
   assign s.addr   = s_addr_q;
   assign s.wdata  = s_wdata_q;
   assign s.wstrb  = s_wstrb_q;
   assign m0.ready = ready_q[0];
   assign m0.rdata = rdata_q[0];
   assign m1.ready = ready_q[1];
   assign m1.rdata = rdata_q[1];
endmodule

// File: tb/tb_picorv_mem_arbiter.sv
// Bench for picorv_mem_arbiter: three instances (RR, fixed priority, watchdog off)
// share one stimulus stream and are checked against a transaction-level model.
module tb_picorv_mem_arbiter;
   localparam int unsigned TO = 4;

   logic clk = 1'b0;
   logic resetn;
   logic a_err, b_err, c_err;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   c_err_seen = 1'b0;

   // Reference model state: last round-robin winner and each requester's rdata.
   bit          last_a;
   logic [31:0] exp_a [2];
   logic [31:0] exp_b [2];
   logic [31:0] p_addr [2];
   logic [31:0] p_wdata [2];
   logic [3:0]  p_wstrb [2];
   bit          p_instr [2];

   picorv_mem_arbiter_if a_m0 (), a_m1 (), a_s ();
   picorv_mem_arbiter_if b_m0 (), b_m1 (), b_s ();
   picorv_mem_arbiter_if c_m0 (), c_m1 (), c_s ();

   picorv_mem_arbiter #(.RR(1'b1), .TIMEOUT(TO)) dut_a (
      .clk(clk), .resetn(resetn), .m0(a_m0), .m1(a_m1), .s(a_s), .timeout_err(a_err));
   picorv_mem_arbiter #(.RR(1'b0), .TIMEOUT(TO)) dut_b (
      .clk(clk), .resetn(resetn), .m0(b_m0), .m1(b_m1), .s(b_s), .timeout_err(b_err));
   picorv_mem_arbiter #(.RR(1'b1), .TIMEOUT(0)) dut_c (
      .clk(clk), .resetn(resetn), .m0(c_m0), .m1(c_m1), .s(c_s), .timeout_err(c_err));

   assign {b_m0.valid, b_m0.instr, b_m0.addr, b_m0.wdata, b_m0.wstrb} =
          {a_m0.valid, a_m0.instr, a_m0.addr, a_m0.wdata, a_m0.wstrb};
   assign {b_m1.valid, b_m1.instr, b_m1.addr, b_m1.wdata, b_m1.wstrb} =
          {a_m1.valid, a_m1.instr, a_m1.addr, a_m1.wdata, a_m1.wstrb};
   assign {c_m0.valid, c_m0.instr, c_m0.addr, c_m0.wdata, c_m0.wstrb} =
          {a_m0.valid, a_m0.instr, a_m0.addr, a_m0.wdata, a_m0.wstrb};
   assign {c_m1.valid, c_m1.instr, c_m1.addr, c_m1.wdata, c_m1.wstrb} =
          {a_m1.valid, a_m1.instr, a_m1.addr, a_m1.wdata, a_m1.wstrb};
   assign {b_s.ready, b_s.rdata} = {a_s.ready, a_s.rdata};
   assign {c_s.ready, c_s.rdata} = {a_s.ready, a_s.rdata};

   always #5 clk = ~clk;

   always @(posedge clk) if (c_err === 1'b1) c_err_seen <= 1'b1;

   task automatic rand_payload();
      for (int i = 0; i < 2; i++) begin
         p_addr[i]  = $urandom;
         p_wdata[i] = $urandom;
         p_wstrb[i] = 4'($urandom);
         p_instr[i] = 1'($urandom);
      end
      p_addr[0][0] = 1'b0;
      p_addr[1][0] = 1'b1;
   endtask

   task automatic drive_req(input bit v0, input bit v1);
      a_m0.valid = v0; a_m0.instr = p_instr[0]; a_m0.addr = p_addr[0];
      a_m0.wdata = p_wdata[0]; a_m0.wstrb = p_wstrb[0];
      a_m1.valid = v1; a_m1.instr = p_instr[1]; a_m1.addr = p_addr[1];
      a_m1.wdata = p_wdata[1]; a_m1.wstrb = p_wstrb[1];
   endtask

   task automatic model_reset();
      last_a = 1'b1;
      for (int i = 0; i < 2; i++) begin
         exp_a[i] = '0;
         exp_b[i] = '0;
      end
   endtask

   // One full transaction: grant, d wait cycles, completion, release.
   task automatic do_txn(input bit v0, input bit v1, input int d, input logic [31:0] rd,
                         input bit drop, input bit jitter);
      bit wa, wb;
      wa = (v0 && v1) ? !last_a : v1;
      wb = (v0 && v1) ? 1'b0 : v1;
      last_a = wa;
      drive_req(v0, v1);
      @(posedge clk); #1;
      n_checks++;
      if ({a_s.valid, a_s.instr, a_s.addr, a_s.wdata, a_s.wstrb} !==
          {1'b1, p_instr[wa], p_addr[wa], p_wdata[wa], p_wstrb[wa]}) begin
         n_fail++;
         $display("FAIL grant_rr: got v=%b i=%b a=%h w=%h s=%h, want req%0d a=%h w=%h s=%h",
                  a_s.valid, a_s.instr, a_s.addr, a_s.wdata, a_s.wstrb,
                  wa, p_addr[wa], p_wdata[wa], p_wstrb[wa]);
      end
      n_checks++;
      if ({b_s.valid, b_s.addr, b_s.wstrb} !== {1'b1, p_addr[wb], p_wstrb[wb]}) begin
         n_fail++;
         $display("FAIL grant_fixed: got v=%b a=%h s=%h, want req%0d a=%h s=%h",
                  b_s.valid, b_s.addr, b_s.wstrb, wb, p_addr[wb], p_wstrb[wb]);
      end
      for (int i = 0; i < d; i++) begin
         if (jitter) begin
            a_m0.addr = $urandom; a_m0.wdata = $urandom; a_m0.wstrb = 4'($urandom);
            a_m1.addr = $urandom; a_m1.wdata = $urandom; a_m1.instr = 1'($urandom);
         end
         if (drop && i == 0) begin
            if (wa) a_m1.valid = 1'b0;
            else    a_m0.valid = 1'b0;
         end
         @(posedge clk); #1;
         n_checks++;
         if ({a_s.valid, a_s.instr, a_s.addr, a_s.wdata, a_s.wstrb, a_m0.ready, a_m1.ready, a_err} !==
             {1'b1, p_instr[wa], p_addr[wa], p_wdata[wa], p_wstrb[wa], 3'b000}) begin
            n_fail++;
            $display("FAIL busy_hold cyc %0d: got v=%b a=%h w=%h s=%h rdy=%b%b err=%b, want a=%h w=%h s=%h",
                     i, a_s.valid, a_s.addr, a_s.wdata, a_s.wstrb, a_m1.ready, a_m0.ready, a_err,
                     p_addr[wa], p_wdata[wa], p_wstrb[wa]);
         end
      end
      a_s.ready = 1'b1;
      a_s.rdata = rd;
      @(posedge clk); #1;
      exp_a[wa] = rd;
      exp_b[wb] = rd;
      n_checks++;
      if ({a_s.valid, a_m1.ready, a_m0.ready, a_err, a_m0.rdata, a_m1.rdata} !==
          {1'b0, wa, !wa, 1'b0, exp_a[0], exp_a[1]}) begin
         n_fail++;
         $display("FAIL done_rr: got v=%b rdy=%b%b err=%b rd0=%h rd1=%h, want rdy req%0d rd0=%h rd1=%h",
                  a_s.valid, a_m1.ready, a_m0.ready, a_err, a_m0.rdata, a_m1.rdata,
                  wa, exp_a[0], exp_a[1]);
      end
      n_checks++;
      if ({b_s.valid, b_m1.ready, b_m0.ready, b_err, b_m0.rdata, b_m1.rdata} !==
          {1'b0, wb, !wb, 1'b0, exp_b[0], exp_b[1]}) begin
         n_fail++;
         $display("FAIL done_fixed: got v=%b rdy=%b%b err=%b rd0=%h rd1=%h, want rdy req%0d rd0=%h rd1=%h",
                  b_s.valid, b_m1.ready, b_m0.ready, b_err, b_m0.rdata, b_m1.rdata,
                  wb, exp_b[0], exp_b[1]);
      end
      a_s.ready = 1'b0;
      a_s.rdata = $urandom;
      @(posedge clk); #1;
      n_checks++;
      if ({a_s.valid, a_m0.ready, a_m1.ready, a_err, b_s.valid, b_m0.ready, b_m1.ready, b_err} !== 8'h00) begin
         n_fail++;
         $display("FAIL release: got a v=%b rdy=%b%b err=%b b v=%b rdy=%b%b err=%b, want all 0",
                  a_s.valid, a_m1.ready, a_m0.ready, a_err, b_s.valid, b_m1.ready, b_m0.ready, b_err);
      end
      a_m0.valid = 1'b0;
      a_m1.valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      n_checks++;
      if ({a_s.valid, a_s.instr, a_s.addr, a_s.wdata, a_s.wstrb, a_m0.ready, a_m1.ready,
           a_m0.rdata, a_m1.rdata, a_err, b_s.valid, b_s.addr, b_m0.rdata, b_m1.rdata,
           c_s.valid, c_s.addr, c_m0.rdata} !== '0) begin
         n_fail++;
         $display("FAIL %s: got v=%b a=%h w=%h s=%h rdy=%b%b rd0=%h rd1=%h err=%b bv=%b cv=%b, want all 0",
                  tag, a_s.valid, a_s.addr, a_s.wdata, a_s.wstrb, a_m1.ready, a_m0.ready,
                  a_m0.rdata, a_m1.rdata, a_err, b_s.valid, c_s.valid);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      a_s.ready = 1'b0;
      a_s.rdata = '0;
      rand_payload();
      drive_req(1'b0, 1'b0);
      model_reset();
      #1;
      check_all_zero("reset_state");
      #12 resetn = 1'b1;
      @(posedge clk); #1;
      check_all_zero("idle_no_request");
   endtask

   task automatic test_contention();
      for (int i = 0; i < 4; i++) begin
         rand_payload();
         do_txn(1'b1, 1'b1, $urandom_range(0, 3), $urandom, 1'b0, 1'b0);
      end
   endtask

   task automatic test_single_read();
      rand_payload();
      p_addr[0]  = 32'h0000_0100;
      p_wstrb[0] = 4'b0000;
      p_instr[0] = 1'b0;
      do_txn(1'b1, 1'b0, 3, 32'h1234_5678, 1'b0, 1'b0);
   endtask

   task automatic test_write_stable();
      rand_payload();
      p_wstrb[1] = 4'b0101;
      p_wdata[1] = 32'hAABB_CCDD;
      do_txn(1'b0, 1'b1, 3, $urandom, 1'b0, 1'b1);
   endtask

   task automatic test_coincident();
      rand_payload();
      do_txn(1'b1, 1'b0, TO, $urandom, 1'b0, 1'b0);
      rand_payload();
      do_txn(1'b0, 1'b1, TO, $urandom, 1'b0, 1'b1);
   endtask

   task automatic test_timeout();
      logic [31:0] rd;
      rand_payload();
      last_a = 1'b0;
      drive_req(1'b1, 1'b0);
      @(posedge clk); #1;
      n_checks++;
      if ({a_s.valid, a_s.addr} !== {1'b1, p_addr[0]}) begin
         n_fail++;
         $display("FAIL to_grant: got v=%b a=%h, want v=1 a=%h", a_s.valid, a_s.addr, p_addr[0]);
      end
      for (int i = 1; i <= int'(TO); i++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({a_s.valid, a_m0.ready, a_err, b_err} !== 4'b1000) begin
            n_fail++;
            $display("FAIL to_wait cyc %0d: got v=%b rdy=%b err=%b berr=%b, want v=1 rdy=0 err=0",
                     i, a_s.valid, a_m0.ready, a_err, b_err);
         end
      end
      @(posedge clk); #1;
      exp_a[0] = 32'hDEAD_BEEF;
      exp_b[0] = 32'hDEAD_BEEF;
      n_checks++;
      if ({a_s.valid, a_m0.ready, a_m1.ready, a_err, a_m0.rdata, b_err, b_m0.ready, b_m0.rdata, c_s.valid} !==
          {1'b0, 1'b1, 1'b0, 1'b1, exp_a[0], 1'b1, 1'b1, exp_b[0], 1'b1}) begin
         n_fail++;
         $display("FAIL to_fire: got v=%b rdy=%b%b err=%b rd0=%h berr=%b brd0=%h cv=%b, want v=0 rdy=01 err=1 rd0=deadbeef cv=1",
                  a_s.valid, a_m1.ready, a_m0.ready, a_err, a_m0.rdata, b_err, b_m0.rdata, c_s.valid);
      end
      a_m0.valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({a_s.valid, a_m0.ready, a_err, b_err, c_s.valid, c_err_seen} !== 6'b000010) begin
         n_fail++;
         $display("FAIL to_release: got v=%b rdy=%b err=%b berr=%b cv=%b cerr=%b, want cv=1 rest 0",
                  a_s.valid, a_m0.ready, a_err, b_err, c_s.valid, c_err_seen);
      end
      rd = $urandom;
      rand_payload();
      do_txn(1'b0, 1'b1, 2, rd, 1'b0, 1'b0);
      n_checks++;
      if ({c_s.valid, c_m0.rdata, c_err_seen} !== {1'b0, rd, 1'b0}) begin
         n_fail++;
         $display("FAIL to_disabled: got cv=%b crd0=%h cerr=%b, want cv=0 crd0=%h cerr=0",
                  c_s.valid, c_m0.rdata, c_err_seen, rd);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         int v;
         v = $urandom_range(1, 3);
         rand_payload();
         do_txn(1'(v & 1), 1'(v >> 1), $urandom_range(0, TO), $urandom,
                $urandom_range(0, 7) == 0, 1'($urandom));
      end
   endtask

   task automatic test_reset_busy();
      rand_payload();
      drive_req(1'b1, 1'b1);
      @(posedge clk); #1;
      n_checks++;
      if (a_s.valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rb_grant: got v=%b, want 1", a_s.valid);
      end
      #3 resetn = 1'b0;
      #1;
      check_all_zero("reset_mid_busy");
      drive_req(1'b0, 1'b0);
      a_s.ready = 1'b1;
      a_s.rdata = $urandom;
      #3 resetn = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({a_s.valid, a_m0.ready, a_m1.ready, a_err, b_m0.ready, b_m1.ready, c_m0.ready, c_m1.ready} !== 8'h00) begin
         n_fail++;
         $display("FAIL rb_no_ready: got v=%b rdy=%b%b err=%b brdy=%b%b crdy=%b%b, want all 0",
                  a_s.valid, a_m1.ready, a_m0.ready, a_err, b_m1.ready, b_m0.ready, c_m1.ready, c_m0.ready);
      end
      a_s.ready = 1'b0;
      model_reset();
      rand_payload();
      do_txn(1'b1, 1'b1, 1, $urandom, 1'b0, 1'b0);
      rand_payload();
      do_txn(1'b1, 1'b1, 0, $urandom, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single_read();
      test_write_stable();
      test_coincident();
      test_timeout();
      test_random();
      test_reset_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete by %0t", $time);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/picorv_mem_arbiter.md
PICORV_MEM_ARBITER -- requirements
Module: picorv_mem_arbiter

Interface
REQ-001 Parameter RR, default 1, meaning 1 = round-robin, 0 = fixed priority with m0 winning.
REQ-002 Parameter TIMEOUT, default 255, meaning BUSY-cycle limit before forced completion; 0 disables the limit.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 m0_valid, m0_instr  input  1 each  requester 0 request and instruction flag.
REQ-006 m0_addr, m0_wdata  input  32 each  requester 0 address and write data.
REQ-007 m0_wstrb  input  4  requester 0 byte strobes; 0000 = read.
REQ-008 m0_ready  output  1  requester 0 completion pulse.
REQ-009 m0_rdata  output  32  requester 0 read data.
REQ-010 m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: identical to REQ-005..009 for requester 1.
REQ-011 s_valid, s_instr  output  1 each  downstream request and instruction flag (to the PicoRV32-native/FreeAHB adapter).
REQ-012 s_addr, s_wdata  output  32 each  downstream address and write data.
REQ-013 s_wstrb  output  4  downstream byte strobes.
REQ-014 s_ready  input  1  downstream completion.
REQ-015 s_rdata  input  32  downstream read data.
REQ-016 timeout_err  output  1  one-cycle pulse on forced completion.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, BUSY and RELEASE.
REQ-018 IDLE: if either mX_valid=1, the block SHALL grant a requester, register its instr/addr/wdata/wstrb into s_*, set s_valid=1 at the next edge and go to BUSY.
REQ-019 Arbitration, RR=1: both valid -> grant the requester not in last_grant; one valid -> grant it.
REQ-020 Arbitration, RR=0: m0 SHALL always win when both are valid.
REQ-021 last_grant SHALL update on every grant.
REQ-022 BUSY: s_* SHALL stay stable and ignore all requester input changes until completion.
REQ-023 BUSY with s_ready=1 at edge M: at edge M, s_valid<=0, granted mX_ready<=1 for exactly one cycle, mX_rdata<=s_rdata (captured for writes too), state<=RELEASE.
REQ-024 RELEASE: the block SHALL assert no ready and no s_valid, then go to IDLE unconditionally after one cycle, so a requester's still-high valid is never re-served.
REQ-025 Latency: mX_valid sampled in IDLE at edge N -> s_valid=1 after N; s_ready at edge M -> mX_ready=1 during cycle M..M+1; earliest next grant at edge M+2.
REQ-026 The non-granted requester's ready SHALL stay 0 and its rdata SHALL hold its last value.
REQ-027 Timeout: an 8-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle without s_ready.
REQ-028 When TIMEOUT!=0 and the counter equals TIMEOUT, the block SHALL do: s_valid<=0, mX_ready pulse, mX_rdata<=32'hDEADBEEF, timeout_err pulse, state<=RELEASE.
REQ-029 When s_ready and the timeout occur in the same cycle, s_ready SHALL take precedence and no error SHALL be raised.
REQ-030 A requester dropping valid during BUSY (protocol violation) SHALL NOT abort the downstream transfer; the ready pulse is still issued.

Reset
REQ-031 resetn=0 SHALL asynchronously force: state IDLE; s_valid, s_instr, m0_ready, m1_ready and timeout_err = 0; s_addr, s_wdata, s_wstrb, m0_rdata, m1_rdata = 0; counter 0; last_grant=1 (m0 wins first contention).
REQ-032 Reset asserted mid-BUSY SHALL drop s_valid immediately and issue no ready pulse after release.

Verification
REQ-033 Single m0 read of addr 0x100 with s_ready after 3 cycles and s_rdata=0x12345678 -> s_addr=0x100, s_wstrb=0, m0_ready one cycle, m0_rdata=0x12345678.
REQ-034 m0 and m1 both valid continuously, RR=1 -> grants alternate m0, m1, m0, m1; RR=0 -> m0 granted every time.
REQ-035 m1 write with wstrb=0101 and wdata=0xAABBCCDD; m0 changes addr during BUSY -> s_* constant, only m1_ready pulses.
REQ-036 TIMEOUT=4, s_ready held 0 -> after 4 BUSY cycles: timeout_err pulse, m0_rdata=0xDEADBEEF, s_valid=0, FSM back in IDLE two cycles later.
REQ-037 s_ready coincident with the timeout cycle -> rdata=s_rdata, timeout_err=0.
REQ-038 resetn pulsed low during BUSY -> all outputs 0 asynchronously; first post-reset contention grants m0.
